// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial add/subtract datapaths.
// Holds the control FSM state encoding and the default operand width.
package serial_arith_pkg;

  localparam int SERIAL_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor, x - y - bin; purely combinational, zero latency.
// No flow control: the outputs follow the inputs.
module full_subtractor (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_xy_diff;

  assign w_xy_diff = i_x ^ i_y;
  assign o_d       = w_xy_diff ^ i_bin;
  // Borrow out when y exceeds x, or when they are equal and a borrow is pending.
  assign o_bout    = (~i_x & i_y) | (~w_xy_diff & i_bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned A-B, LSB first: St at edge k -> Busy in cycles k+1..k+N, Done in cycle k+N+1.
// No backpressure: Ld/St are only honoured in IDLE/DONE and ignored while shifting.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int N  = SERIAL_W_DEFAULT,
  parameter int CW = $clog2(N)
) (
  input  logic         CLK,
  input  logic         Rst_n,
  input  logic         Ld,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         St,
  output logic [N-1:0] Diff,
  output logic         Borrow,
  output logic         Busy,
  output logic         Done
);

  state_t        r_state;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_sub;
  logic          r_borrow;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  logic          w_d;
  logic          w_bout;

  full_subtractor u_fs (
    .i_x    (r_acc[0]),
    .i_y    (r_sub[0]),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  always_ff @(posedge CLK) begin
    if (!Rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_sub    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          // Ld has priority over St when both arrive together.
          if (Ld) begin
            r_acc    <= A;
            r_sub    <= B;
            r_borrow <= 1'b0;
          end else if (St) begin
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_state  <= SHIFT;
            r_busy   <= 1'b1;
          end
        end
        SHIFT: begin
          r_acc    <= {w_d, r_acc[N-1:1]};
          r_sub    <= {1'b0, r_sub[N-1:1]};
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(N - 1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Diff   = r_acc;
  assign Borrow = r_borrow;
  assign Busy   = r_busy;
  assign Done   = r_done;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed and table-driven bench for serial_subtractor at N=4 and N=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld4, st4, ld8, st8;
  logic [3:0] a4, b4, diff4;
  logic [7:0] a8, b8, diff8;
  logic       borrow4, busy4, done4;
  logic       borrow8, busy8, done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(4)) u_dut4 (
    .CLK(clk), .Rst_n(rst_n), .Ld(ld4), .A(a4), .B(b4), .St(st4),
    .Diff(diff4), .Borrow(borrow4), .Busy(busy4), .Done(done4)
  );

  serial_subtractor #(.N(8)) u_dut8 (
    .CLK(clk), .Rst_n(rst_n), .Ld(ld8), .A(a8), .B(b8), .St(st8),
    .Diff(diff8), .Borrow(borrow8), .Busy(busy8), .Done(done8)
  );

  typedef struct packed {
    logic       w8;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] get_diff(input logic w8);
    return w8 ? diff8 : {4'b0, diff4};
  endfunction

  // All tasks start and end at a falling edge.
  task automatic do_load(input logic w8, input logic [7:0] a, input logic [7:0] b);
    if (w8) begin ld8 = 1'b1; a8 = a; b8 = b; end
    else begin ld4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; end
    @(negedge clk);
    ld4 = 1'b0;
    ld8 = 1'b0;
  endtask

  task automatic do_start(input logic w8);
    if (w8) st8 = 1'b1; else st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    st8 = 1'b0;
  endtask

  // Called in the first cycle after the St edge; returns in the Done cycle.
  task automatic wait_result(input logic w8, input logic [7:0] ed, input logic eb);
    int busy_cnt = 0;
    int done_at  = 0;
    int n        = w8 ? 8 : 4;
    for (int c = 1; c <= 20 && done_at == 0; c++) begin
      if (w8 ? busy8 : busy4) busy_cnt++;
      if (w8 ? done8 : done4) done_at = c;
      if (done_at == 0) @(negedge clk);
    end
    chk("busy_len", busy_cnt, n);
    chk("done_latency", done_at, n + 1);
    chk("diff", get_diff(w8), ed);
    chk("borrow", w8 ? borrow8 : borrow4, eb);
  endtask

  task automatic op(input logic w8, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] ed, input logic eb);
    do_load(w8, a, b);
    do_start(w8);
    wait_result(w8, ed, eb);
  endtask

  initial begin
    int dcnt;
    int dat;
    logic [7:0] dval;
    logic [7:0] ra, rb;

    tbl[0] = '{1'b0, 8'd9,   8'd3,  8'd6,   1'b0};
    tbl[1] = '{1'b0, 8'd3,   8'd9,  8'hA,   1'b1};
    tbl[2] = '{1'b0, 8'd0,   8'd1,  8'hF,   1'b1};
    tbl[3] = '{1'b0, 8'd7,   8'd7,  8'd0,   1'b0};
    tbl[4] = '{1'b0, 8'd15,  8'd0,  8'd15,  1'b0};
    tbl[5] = '{1'b0, 8'd0,   8'd15, 8'd1,   1'b1};
    tbl[6] = '{1'b1, 8'd200, 8'd55, 8'd145, 1'b0};
    tbl[7] = '{1'b1, 8'd55,  8'd200, 8'd111, 1'b1};
    tbl[8] = '{1'b1, 8'd255, 8'd255, 8'd0,  1'b0};
    tbl[9] = '{1'b1, 8'd0,   8'd255, 8'd1,  1'b1};

    rst_n = 1'b0;
    ld4 = 1'b0; st4 = 1'b0; a4 = '0; b4 = '0;
    ld8 = 1'b0; st8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_diff4", diff4, 0);
    chk("rst_borrow4", borrow4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_diff8", diff8, 0);
    chk("rst_busy8", busy8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      op(tbl[i].w8, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo);

    // Ld and St during SHIFT must be ignored.
    do_load(1'b0, 8'd9, 8'd3);
    do_start(1'b0);
    dcnt = 0; dat = 0; dval = '0;
    ld4 = 1'b1; a4 = 4'd1; b4 = 4'd1; st4 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      if (done4) begin dcnt++; dat = c; dval = {4'b0, diff4}; end
      @(negedge clk);
      if (c == 2) begin ld4 = 1'b0; st4 = 1'b0; end
    end
    chk("ign_done_count", dcnt, 1);
    chk("ign_done_at", dat, 5);
    chk("ign_diff", dval, 6);

    // Synchronous reset in the second SHIFT cycle.
    do_load(1'b0, 8'd9, 8'd3);
    do_start(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_diff", diff4, 0);
    chk("midrst_borrow", borrow4, 0);
    chk("midrst_busy", busy4, 0);
    chk("midrst_done", done4, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle_busy", busy4, 0);
    op(1'b0, 8'd5, 8'd2, 8'd3, 1'b0);

    // Back-to-back: load in the DONE cycle, then start.
    op(1'b0, 8'd3, 8'd9, 8'hA, 1'b1);
    do_load(1'b0, 8'd12, 8'd4);
    chk("b2b_gap_busy", busy4, 0);
    chk("b2b_gap_done", done4, 0);
    do_start(1'b0);
    wait_result(1'b0, 8'd8, 1'b0);

    // Results hold after Done; a start without Ld uses acc minus the drained sub.
    @(negedge clk);
    chk("hold_diff", diff4, 8);
    chk("hold_done_low", done4, 0);
    do_start(1'b0);
    wait_result(1'b0, 8'd8, 1'b0);

    // Borrow must be cleared by Ld even without a start.
    op(1'b0, 8'd0, 8'd1, 8'hF, 1'b1);
    do_load(1'b0, 8'd4, 8'd4);
    chk("ld_clears_borrow", borrow4, 0);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op(1'b1, ra, rb, ra - rb, (ra < rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
